arrow_sprite_scheduler: RTL and testbench

- Per-scanline sprite scheduler for the arrow and receptor sprite tables.
- During horizontal blanking it scans the object table (note objects: position, arrow type, valid) and latches up to MAX_PER_LINE objects that intersect the next scanline into a line buffer.
- During active video it resolves, per pixel, which latched object covers DrawX. It then drives the sprite-table select and the SpriteX/SpriteY lookup coordinates to the colour mapper.

---
 rtl/arrow_sprite_scheduler.sv | 161 ++++++++++++++++
 tb/tb_arrow_sprite_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/arrow_sprite_scheduler.sv
// arrow_sprite_scheduler: per-scanline object scan into a line buffer plus per-pixel sprite resolve
module arrow_sprite_scheduler #(
  parameter int NUM_OBJ      = 16,
  parameter int MAX_PER_LINE = 4,
  parameter int SPR_SIZE     = 64
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       line_start,
  input  logic [9:0]                 LineY,
  input  logic [9:0]                 DrawX,
  output logic [$clog2(NUM_OBJ)-1:0] obj_idx,
  input  logic [9:0]                 obj_x,
  input  logic [9:0]                 obj_y,
  input  logic [1:0]                 obj_type,
  input  logic                       obj_valid,
  output logic                       scan_busy,
  output logic                       line_overflow,
  output logic                       sprite_on,
  output logic [1:0]                 sprite_type,
  output logic [9:0]                 SpriteX,
  output logic [9:0]                 SpriteY
);
  localparam int IW = $clog2(NUM_OBJ);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam logic [9:0] SZ = 10'(SPR_SIZE);
  localparam logic [10:0] SZW = 11'(SPR_SIZE);
  typedef enum logic [1:0] {IDLE, SCAN, SWAP} state_t;
  state_t state_q, state_d;
  logic [9:0] scan_y_q, scan_y_d;
  logic [IW:0] cnt_q, cnt_d;
  logic [9:0] bx_q [MAX_PER_LINE], bx_d [MAX_PER_LINE];
  logic [9:0] brow_q [MAX_PER_LINE], brow_d [MAX_PER_LINE];
  logic [1:0] btype_q [MAX_PER_LINE], btype_d [MAX_PER_LINE];
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic bovf_q, bovf_d;
  logic [9:0] dx_q [MAX_PER_LINE], dx_d [MAX_PER_LINE];
  logic [9:0] drow_q [MAX_PER_LINE], drow_d [MAX_PER_LINE];
  logic [1:0] dtype_q [MAX_PER_LINE], dtype_d [MAX_PER_LINE];
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic ovf_q, ovf_d;
  logic sprite_on_q, sprite_on_d;
  logic [1:0] sprite_type_q, sprite_type_d;
  logic [9:0] sprite_x_q, sprite_x_d;
  logic [9:0] sprite_y_q, sprite_y_d;
  logic hit;
  // cnt runs one past the last index so the final read can be evaluated; the address saturates there
  assign obj_idx = cnt_q[IW] ? IW'(NUM_OBJ - 1) : cnt_q[IW-1:0];
  assign scan_busy = state_q != IDLE;
  assign line_overflow = ovf_q;
  assign sprite_on = sprite_on_q;
  assign sprite_type = sprite_type_q;
  assign SpriteX = sprite_x_q;
  assign SpriteY = sprite_y_q;
  // Scan FSM: a new line_start always restarts, and mid-scan it also blanks the display buffer
  always_comb begin
    state_d = state_q;
    scan_y_d = scan_y_q;
    cnt_d = cnt_q;
    bx_d = bx_q;
    brow_d = brow_q;
    btype_d = btype_q;
    bcnt_d = bcnt_q;
    bovf_d = bovf_q;
    dx_d = dx_q;
    drow_d = drow_q;
    dtype_d = dtype_q;
    dcnt_d = dcnt_q;
    ovf_d = ovf_q;
    hit = obj_valid && obj_y <= scan_y_q && {1'b0, scan_y_q} < {1'b0, obj_y} + SZW;
    if (line_start) begin
      state_d = SCAN;
      scan_y_d = LineY;
      cnt_d = '0;
      bcnt_d = '0;
      bovf_d = 1'b0;
      if (state_q != IDLE) begin
        dcnt_d = '0;
        ovf_d = 1'b0;
      end
    end else if (state_q == SCAN) begin
      cnt_d = cnt_q + (IW+1)'(1);
      if (cnt_q != '0 && hit) begin
        if (bcnt_q < CW'(MAX_PER_LINE)) begin
          for (int i = 0; i < MAX_PER_LINE; i++)
            if (CW'(i) == bcnt_q) begin
              bx_d[i] = obj_x;
              brow_d[i] = scan_y_q - obj_y;
              btype_d[i] = obj_type;
            end
          bcnt_d = bcnt_q + CW'(1);
        end else
          bovf_d = 1'b1;
      end
      if (cnt_q == (IW+1)'(NUM_OBJ)) begin
        state_d = SWAP;
        cnt_d = '0;
      end
    end else if (state_q == SWAP) begin
      dx_d = bx_q;
      drow_d = brow_q;
      dtype_d = btype_q;
      dcnt_d = bcnt_q;
      ovf_d = bovf_q;
      state_d = IDLE;
    end
  end
  // Pixel resolve: walk slots high to low so the lowest covering slot overrides
  always_comb begin
    sprite_on_d = 1'b0;
    sprite_type_d = '0;
    sprite_x_d = '0;
    sprite_y_d = '0;
    for (int i = MAX_PER_LINE - 1; i >= 0; i--)
      if (CW'(i) < dcnt_q && DrawX >= dx_q[i] && {1'b0, DrawX} < {1'b0, dx_q[i]} + SZW) begin
        sprite_on_d = 1'b1;
        sprite_type_d = dtype_q[i];
        sprite_x_d = SZ - (DrawX - dx_q[i]);
        sprite_y_d = SZ - drow_q[i];
      end
  end
  // State, line buffers and registered pixel outputs
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= IDLE;
      scan_y_q <= '0;
      cnt_q <= '0;
      bx_q <= '{default: '0};
      brow_q <= '{default: '0};
      btype_q <= '{default: '0};
      bcnt_q <= '0;
      bovf_q <= 1'b0;
      dx_q <= '{default: '0};
      drow_q <= '{default: '0};
      dtype_q <= '{default: '0};
      dcnt_q <= '0;
      ovf_q <= 1'b0;
      sprite_on_q <= 1'b0;
      sprite_type_q <= '0;
      sprite_x_q <= '0;
      sprite_y_q <= '0;
    end else begin
      state_q <= state_d;
      scan_y_q <= scan_y_d;
      cnt_q <= cnt_d;
      bx_q <= bx_d;
      brow_q <= brow_d;
      btype_q <= btype_d;
      bcnt_q <= bcnt_d;
      bovf_q <= bovf_d;
      dx_q <= dx_d;
      drow_q <= drow_d;
      dtype_q <= dtype_d;
      dcnt_q <= dcnt_d;
      ovf_q <= ovf_d;
      sprite_on_q <= sprite_on_d;
      sprite_type_q <= sprite_type_d;
      sprite_x_q <= sprite_x_d;
      sprite_y_q <= sprite_y_d;
    end
endmodule

// File: tb/tb_arrow_sprite_scheduler.sv
// tb_arrow_sprite_scheduler: object-table model, line runner and pixel scoreboard for the scheduler
module tb_arrow_sprite_scheduler;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic line_start = 1'b0;
  logic [9:0] LineY = '0;
  logic [9:0] DrawX = '0;
  logic [3:0] obj_idx;
  logic [9:0] obj_x, obj_y;
  logic [1:0] obj_type;
  logic obj_valid;
  logic scan_busy, line_overflow, sprite_on;
  logic [1:0] sprite_type;
  logic [9:0] SpriteX, SpriteY;
  typedef struct packed {
    logic [9:0] x;
    logic       on;
    logic [1:0] t;
    logic [9:0] sx;
    logic [9:0] sy;
  } pix_t;
  logic [9:0] mx [16];
  logic [9:0] my [16];
  logic [1:0] mt [16];
  logic       mv [16];
  pix_t exp_q [$];
  pix_t e;
  pix_t tbl2 [5];
  int n_chk = 0;
  int n_fail = 0;
  always #5 Clk = ~Clk;
  arrow_sprite_scheduler dut (
    .Clk(Clk), .Reset_n(Reset_n), .line_start(line_start), .LineY(LineY), .DrawX(DrawX),
    .obj_idx(obj_idx), .obj_x(obj_x), .obj_y(obj_y), .obj_type(obj_type), .obj_valid(obj_valid),
    .scan_busy(scan_busy), .line_overflow(line_overflow), .sprite_on(sprite_on),
    .sprite_type(sprite_type), .SpriteX(SpriteX), .SpriteY(SpriteY)
  );
  // Object table with one cycle of read latency
  always @(posedge Clk) begin
    obj_x <= mx[obj_idx];
    obj_y <= my[obj_idx];
    obj_type <= mt[obj_idx];
    obj_valid <= mv[obj_idx];
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Pixel scoreboard: each DrawX driven at a negedge is due right after the next posedge
  always @(posedge Clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("x%0d_on", e.x), sprite_on, e.on);
      chk($sformatf("x%0d_type", e.x), sprite_type, e.t);
      chk($sformatf("x%0d_spritex", e.x), SpriteX, e.sx);
      chk($sformatf("x%0d_spritey", e.x), SpriteY, e.sy);
    end
  end
  task automatic pix(input pix_t p);
    @(negedge Clk);
    DrawX = p.x;
    exp_q.push_back(p);
  endtask
  task automatic flush();
    repeat (2) @(negedge Clk);
  endtask
  task automatic clr_mem();
    for (int i = 0; i < 16; i++) begin
      mx[i] = '0; my[i] = '0; mt[i] = '0; mv[i] = 1'b0;
    end
  endtask
  task automatic set_obj(input int i, input int x, input int y, input int t);
    mx[i] = 10'(x); my[i] = 10'(y); mt[i] = 2'(t); mv[i] = 1'b1;
  endtask
  task automatic run_line(input logic [9:0] y);
    @(negedge Clk);
    line_start = 1'b1;
    LineY = y;
    @(negedge Clk);
    line_start = 1'b0;
    chk("busy_start", scan_busy, 1);
    repeat (17) @(negedge Clk);
    chk("busy_swap", scan_busy, 1);
    @(negedge Clk);
    chk("busy_done", scan_busy, 0);
  endtask
  initial begin
    clr_mem();
    tbl2[0] = '{x: 10'd100, on: 1'b1, t: 2'd2, sx: 10'd64, sy: 10'd54};
    tbl2[1] = '{x: 10'd163, on: 1'b1, t: 2'd2, sx: 10'd1,  sy: 10'd54};
    tbl2[2] = '{x: 10'd164, on: 1'b0, t: 2'd0, sx: 10'd0,  sy: 10'd0};
    tbl2[3] = '{x: 10'd99,  on: 1'b0, t: 2'd0, sx: 10'd0,  sy: 10'd0};
    tbl2[4] = '{x: 10'd130, on: 1'b1, t: 2'd2, sx: 10'd34, sy: 10'd54};
    #1;
    chk("rst_idx", obj_idx, 0);
    chk("rst_busy", scan_busy, 0);
    chk("rst_ovf", line_overflow, 0);
    chk("rst_on", sprite_on, 0);
    chk("rst_type", sprite_type, 0);
    chk("rst_sx", SpriteX, 0);
    chk("rst_sy", SpriteY, 0);
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    // single object, table-driven pixel checks
    set_obj(0, 100, 50, 2);
    run_line(10'd60);
    chk("t2_ovf", line_overflow, 0);
    for (int i = 0; i < 5; i++) pix(tbl2[i]);
    flush();
    // reset three cycles into a scan
    @(negedge Clk);
    DrawX = 10'd100;
    line_start = 1'b1;
    LineY = 10'd60;
    @(negedge Clk);
    line_start = 1'b0;
    repeat (2) @(negedge Clk);
    chk("pre_rst_on", sprite_on, 1);
    Reset_n = 1'b0;
    #1;
    chk("mid_rst_on", sprite_on, 0);
    chk("mid_rst_busy", scan_busy, 0);
    chk("mid_rst_idx", obj_idx, 0);
    chk("mid_rst_sx", SpriteX, 0);
    chk("mid_rst_type", sprite_type, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    pix('{x: 10'd100, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    run_line(10'd60);
    pix('{x: 10'd100, on: 1'b1, t: 2'd2, sx: 10'd64, sy: 10'd54});
    flush();
    // overlapping objects: lower index wins
    clr_mem();
    set_obj(3, 200, 0, 1);
    set_obj(7, 220, 0, 3);
    run_line(10'd10);
    pix('{x: 10'd230, on: 1'b1, t: 2'd1, sx: 10'd34, sy: 10'd54});
    pix('{x: 10'd270, on: 1'b1, t: 2'd3, sx: 10'd14, sy: 10'd54});
    pix('{x: 10'd199, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    // six hits: overflow, then a two-hit line clears it
    clr_mem();
    for (int i = 0; i < 6; i++) set_obj(i, 100 * i, 0, i % 4);
    run_line(10'd5);
    chk("t4_ovf_set", line_overflow, 1);
    pix('{x: 10'd310, on: 1'b1, t: 2'd3, sx: 10'd54, sy: 10'd59});
    pix('{x: 10'd450, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    pix('{x: 10'd550, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    pix('{x: 10'd5, on: 1'b1, t: 2'd0, sx: 10'd59, sy: 10'd59});
    flush();
    for (int i = 2; i < 6; i++) mv[i] = 1'b0;
    run_line(10'd5);
    chk("t4_ovf_clr", line_overflow, 0);
    pix('{x: 10'd210, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    pix('{x: 10'd110, on: 1'b1, t: 2'd1, sx: 10'd54, sy: 10'd59});
    flush();
    // vertical boundaries and right-edge clipping
    clr_mem();
    set_obj(0, 0, 1020, 0);
    set_obj(1, 1000, 10, 1);
    run_line(10'd3);
    pix('{x: 10'd10, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    run_line(10'd74);
    pix('{x: 10'd1010, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    run_line(10'd73);
    pix('{x: 10'd1010, on: 1'b1, t: 2'd1, sx: 10'd54, sy: 10'd1});
    pix('{x: 10'd1023, on: 1'b1, t: 2'd1, sx: 10'd41, sy: 10'd1});
    pix('{x: 10'd5, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    // abort: second line_start five cycles into a scan
    clr_mem();
    set_obj(0, 100, 41, 1);
    set_obj(1, 300, 0, 2);
    for (int i = 2; i < 6; i++) set_obj(i, 100 * i + 300, 0, 3);
    run_line(10'd40);
    chk("t6_pre_ovf", line_overflow, 1);
    pix('{x: 10'd310, on: 1'b1, t: 2'd2, sx: 10'd54, sy: 10'd24});
    pix('{x: 10'd100, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    flush();
    @(negedge Clk);
    DrawX = 10'd310;
    line_start = 1'b1;
    LineY = 10'd40;
    @(negedge Clk);
    line_start = 1'b0;
    @(negedge Clk);
    chk("t6_scan_ovf_held", line_overflow, 1);
    chk("t6_scan_on_held", sprite_on, 1);
    repeat (3) @(negedge Clk);
    line_start = 1'b1;
    LineY = 10'd41;
    @(negedge Clk);
    line_start = 1'b0;
    chk("t6_abort_ovf", line_overflow, 0);
    chk("t6_abort_busy", scan_busy, 1);
    pix('{x: 10'd310, on: 1'b0, t: 2'd0, sx: 10'd0, sy: 10'd0});
    for (int i = 0; i < 40 && scan_busy; i++) @(negedge Clk);
    chk("t6_scan_done", scan_busy, 0);
    chk("t6_final_ovf", line_overflow, 1);
    pix('{x: 10'd100, on: 1'b1, t: 2'd1, sx: 10'd64, sy: 10'd64});
    pix('{x: 10'd310, on: 1'b1, t: 2'd2, sx: 10'd54, sy: 10'd23});
    flush();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
